// File: rtl/conv_accum_if.sv
// conv_accum_if: config, beat-stream and result handshakes between feeder, conv_accum_unit and writeback
interface conv_accum_if #(
  parameter int IN_NUM       = 9,
  parameter int OUT_NUM      = 18,
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int BIAS_WIDTH   = 16,
  parameter int PASS_WIDTH   = 10
);
  logic                                  cfg_valid;
  logic                                  cfg_ready;
  logic [PASS_WIDTH-1:0]                 cfg_passes;
  logic [4:0]                            cfg_shift;
  logic                                  cfg_relu_en;
  logic [BIAS_WIDTH*OUT_NUM-1:0]         bias_in;
  logic [IN_NUM*DATA_WIDTH-1:0]          data_in;
  logic [IN_NUM*WEIGHT_WIDTH*OUT_NUM-1:0] weight_in;
  logic                                  in_valid;
  logic                                  in_ready;
  logic [OUT_NUM*DATA_WIDTH-1:0]         data_out;
  logic                                  out_valid;
  logic                                  out_ready;
  logic                                  busy;
  logic                                  done;
  modport master (
    output cfg_valid, cfg_passes, cfg_shift, cfg_relu_en, bias_in, data_in, weight_in, in_valid, out_ready,
    input  cfg_ready, in_ready, data_out, out_valid, busy, done
  );
  modport slave (
    input  cfg_valid, cfg_passes, cfg_shift, cfg_relu_en, bias_in, data_in, weight_in, in_valid, out_ready,
    output cfg_ready, in_ready, data_out, out_valid, busy, done
  );
endinterface

// File: rtl/conv_accum_unit.sv
// conv_accum_unit: IN_NUM x OUT_NUM signed MAC array with multi-beat accumulation and requantising post-process
module conv_accum_unit #(
  parameter int IN_NUM              = 9,
  parameter int OUT_NUM             = 18,
  parameter int DATA_WIDTH          = 8,
  parameter int WEIGHT_WIDTH        = 8,
  parameter int BIAS_WIDTH          = 16,
  parameter int ACC_WIDTH           = 32,
  parameter int PASS_WIDTH          = 10,
  parameter int MULT_PIPELINE_STAGE = 2
) (
  input logic clk,
  input logic rst,
  conv_accum_if.slave bus
);
  localparam int PW    = DATA_WIDTH + WEIGHT_WIDTH;
  localparam int SUM_W = PW + $clog2(IN_NUM);
  localparam int VW    = ACC_WIDTH + 2;
  localparam int S     = MULT_PIPELINE_STAGE;
  localparam logic signed [VW-1:0] MAXV = VW'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [VW-1:0] MINV = ~MAXV;
  typedef enum logic [2:0] {IDLE, ACCUM, FLUSH, POST, OUT} state_t;
  state_t                       state;
  logic [PASS_WIDTH-1:0]        passes, cnt;
  logic [4:0]                   shift;
  logic                         relu_en, out_valid, accept;
  logic signed [BIAS_WIDTH-1:0] bias [OUT_NUM];
  logic signed [SUM_W-1:0]      sum_in [OUT_NUM];
  logic signed [SUM_W-1:0]      pipe [S][OUT_NUM];
  logic [S-1:0]                 pv;
  logic signed [ACC_WIDTH-1:0]  acc [OUT_NUM];
  logic [DATA_WIDTH-1:0]        res [OUT_NUM];
  logic [OUT_NUM*DATA_WIDTH-1:0] data_q;
  logic signed [VW-1:0]         rnd;
  assign bus.cfg_ready = state == IDLE;
  assign bus.busy      = state != IDLE;
  assign bus.in_ready  = (state == ACCUM) && (cnt < passes);
  assign bus.out_valid = out_valid;
  assign bus.data_out  = data_q;
  assign bus.done      = out_valid & bus.out_ready;
  assign accept        = bus.in_valid & bus.in_ready;
  assign rnd           = (shift == 5'd0) ? '0 : (VW'(1) << (shift - 5'd1));
  always_comb begin
    logic signed [PW-1:0] p;
    logic signed [VW-1:0] v;
    p = '0;
    v = '0;
    for (int j = 0; j < OUT_NUM; j++) begin
      sum_in[j] = '0;
      for (int i = 0; i < IN_NUM; i++) begin
        p = PW'($signed(bus.data_in[i*DATA_WIDTH +: DATA_WIDTH])) *
            PW'($signed(bus.weight_in[(j*IN_NUM+i)*WEIGHT_WIDTH +: WEIGHT_WIDTH]));
        sum_in[j] = sum_in[j] + SUM_W'(p);
      end
      v = VW'(acc[j]) + VW'(bias[j]);
      v = (v + rnd) >>> shift;
      v = (relu_en && v < 0) ? '0 : v;
      v = (v > MAXV) ? MAXV : (v < MINV) ? MINV : v;
      res[j] = v[DATA_WIDTH-1:0];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      passes    <= '0;
      cnt       <= '0;
      shift     <= '0;
      relu_en   <= 1'b0;
      pv        <= '0;
      out_valid <= 1'b0;
      data_q    <= '0;
      for (int j = 0; j < OUT_NUM; j++) begin
        acc[j]  <= '0;
        bias[j] <= '0;
      end
    end else begin
      pv[0]   <= accept;
      pipe[0] <= sum_in;
      for (int s = 1; s < S; s++) begin
        pv[s]   <= pv[s-1];
        pipe[s] <= pipe[s-1];
      end
      if (pv[S-1])
        for (int j = 0; j < OUT_NUM; j++) acc[j] <= acc[j] + ACC_WIDTH'(pipe[S-1][j]);
      case (state)
        IDLE: if (bus.cfg_valid) begin
          passes  <= (bus.cfg_passes == '0) ? PASS_WIDTH'(1) : bus.cfg_passes;
          shift   <= bus.cfg_shift;
          relu_en <= bus.cfg_relu_en;
          cnt     <= '0;
          for (int j = 0; j < OUT_NUM; j++) begin
            acc[j]  <= '0;
            bias[j] <= bus.bias_in[j*BIAS_WIDTH +: BIAS_WIDTH];
          end
          state <= ACCUM;
        end
        ACCUM: if (accept) begin
          cnt <= cnt + PASS_WIDTH'(1);
          if (cnt + PASS_WIDTH'(1) == passes) state <= FLUSH;
        end
        // the final beat is always youngest in the pipe, so an empty pipe means all sums landed
        FLUSH: if (pv == '0) state <= POST;
        POST: begin
          for (int j = 0; j < OUT_NUM; j++) data_q[j*DATA_WIDTH +: DATA_WIDTH] <= res[j];
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: if (bus.out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_accum_unit.sv
// tb_conv_accum_unit: directed and random tiles checked against an arithmetic reference of the conv tile
module tb_conv_accum_unit;
  localparam int NI = 9, NO = 18, MAXB = 8;
  logic clk = 1'b0, rst = 1'b1;
  int total = 0, bad = 0;
  int dq [MAXB][NI];
  int wq [MAXB][NO][NI];
  int bv [NO];
  always #5 clk = ~clk;
  conv_accum_if bus ();
  conv_accum_unit dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic longint model(int j, int np, int sh, int rl);
    longint a = 0;
    for (int b = 0; b < np; b++)
      for (int i = 0; i < NI; i++) a += longint'(dq[b][i]) * longint'(wq[b][j][i]);
    a = a + bv[j];
    if (sh > 0) a = (a + (longint'(1) << (sh - 1))) >>> sh;
    if (rl != 0 && a < 0) a = 0;
    return a > 127 ? 127 : a < -128 ? -128 : a;
  endfunction

  task automatic drive_beat(input int b);
    for (int i = 0; i < NI; i++) bus.data_in[i*8 +: 8] = 8'(dq[b][i]);
    for (int j = 0; j < NO; j++)
      for (int i = 0; i < NI; i++) bus.weight_in[(j*NI+i)*8 +: 8] = 8'(wq[b][j][i]);
  endtask

  task automatic start_tile(input int np, input int sh, input int rl);
    bus.cfg_valid   = 1'b1;
    bus.cfg_passes  = 10'(np);
    bus.cfg_shift   = 5'(sh);
    bus.cfg_relu_en = rl[0];
    for (int j = 0; j < NO; j++) bus.bias_in[j*16 +: 16] = 16'(bv[j]);
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0;
    chk("cfg_ready_busy", {bus.cfg_ready, bus.busy}, 2'b01);
    chk("in_ready_open", bus.in_ready, 1);
  endtask

  task automatic run_tile(input string tag, input int np, input int sh, input int rl, input int gaps, input int stall);
    int b = 0, k = 0, lat = 0;
    logic acc_now;
    logic [NO*8-1:0] snap;
    logic signed [7:0] o;
    start_tile(np, sh, rl);
    while (b < np && k < 200) begin
      bus.in_valid = (gaps != 0) ? ~k[0] : 1'b1;
      drive_beat(b);
      acc_now = bus.in_valid & bus.in_ready;
      @(posedge clk); #1;
      if (acc_now) b++;
      k++;
    end
    bus.in_valid = 1'b0;
    chk({tag, "_beats"}, b, np);
    chk({tag, "_in_ready_drop"}, bus.in_ready, 0);
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, 4);
    snap = bus.data_out;
    for (int c = 0; c < stall; c++) begin
      chk({tag, "_stall_hold"}, {bus.out_valid, bus.in_ready, bus.cfg_ready, bus.done}, 4'b1000);
      chk({tag, "_stall_data"}, (bus.data_out == snap) ? 1 : 0, 1);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    #1;
    chk({tag, "_done"}, {bus.out_valid, bus.done}, 2'b11);
    for (int j = 0; j < NO; j++) begin
      o = bus.data_out[j*8 +: 8];
      chk($sformatf("%s_ch%0d", tag, j), o, model(j, np, sh, rl));
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, "_after"}, {bus.out_valid, bus.done, bus.cfg_ready, bus.busy}, 4'b0010);
  endtask

  task automatic fill(input int d, input int w, input int bias);
    for (int b = 0; b < MAXB; b++)
      for (int i = 0; i < NI; i++) begin
        dq[b][i] = d;
        for (int j = 0; j < NO; j++) wq[b][j][i] = w;
      end
    for (int j = 0; j < NO; j++) bv[j] = bias;
  endtask

  initial begin
    logic signed [7:0] o;
    int np, sh;
    bus.cfg_valid = 0; bus.cfg_passes = '0; bus.cfg_shift = '0; bus.cfg_relu_en = 0;
    bus.bias_in = '0; bus.data_in = '0; bus.weight_in = '0; bus.in_valid = 0; bus.out_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_ctrl", {bus.cfg_ready, bus.busy, bus.in_ready, bus.out_valid, bus.done}, 5'b10000);
    chk("reset_data", (bus.data_out == '0) ? 1 : 0, 1);

    fill(1, 1, 0);
    run_tile("unit", 1, 0, 0, 0, 0);
    chk("unit_ch0_value", model(0, 1, 0, 0), 9);

    fill(10, 10, 100);
    run_tile("possat", 3, 4, 0, 0, 0);

    fill(-5, 3, 0);
    run_tile("relu_on", 1, 0, 1, 0, 0);
    run_tile("relu_off", 1, 0, 0, 0, 0);
    o = bus.data_out[7:0];
    chk("negclamp_direct", o, -128);

    fill(1, 0, 3);
    for (int b = 0; b < MAXB; b++)
      for (int i = 0; i < NI; i++) begin
        wq[b][0][i] = 1;
        wq[b][1][i] = 2;
      end
    run_tile("round", 1, 3, 0, 0, 0);

    fill(0, 0, 0);
    for (int b = 0; b < MAXB; b++)
      for (int i = 0; i < NI; i++) begin
        dq[b][i] = int'($urandom_range(0, 40)) - 20;
        for (int j = 0; j < NO; j++) wq[b][j][i] = int'($urandom_range(0, 40)) - 20;
      end
    for (int j = 0; j < NO; j++) bv[j] = int'($urandom_range(0, 400)) - 200;
    run_tile("gaps_stall", 4, 2, 0, 1, 5);

    // abort a 4-beat tile after two beats; the next tile must not see its partial sums
    fill(7, 7, 0);
    start_tile(4, 0, 0);
    bus.in_valid = 1'b1;
    drive_beat(0);
    repeat (2) @(posedge clk);
    #1 bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_ctrl", {bus.cfg_ready, bus.busy, bus.out_valid, bus.in_ready}, 4'b1000);
    chk("abort_data", (bus.data_out == '0) ? 1 : 0, 1);
    fill(2, 1, 1);
    run_tile("fresh", 1, 0, 0, 0, 0);

    for (int t = 0; t < 5; t++) begin
      np = int'($urandom_range(1, 6));
      sh = int'($urandom_range(0, 12));
      for (int b = 0; b < MAXB; b++)
        for (int i = 0; i < NI; i++) begin
          dq[b][i] = int'($urandom_range(0, 255)) - 128;
          for (int j = 0; j < NO; j++) wq[b][j][i] = int'($urandom_range(0, 255)) - 128;
        end
      for (int j = 0; j < NO; j++) bv[j] = int'($urandom_range(0, 65535)) - 32768;
      run_tile($sformatf("rand%0d", t), np, sh, int'($urandom_range(0, 1)),
               int'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
